// File: rtl/aes_decipher_block_if.sv
// Decipher block bus: start/ciphertext/key-length in, round-key lookup out
// and back, plaintext/ready out.
//   next       start pulse (honoured only while ready)
//   keylen     0 = AES-128, 1 = AES-256 (sampled with next)
//   block      ciphertext (sampled with next)
//   round      round-key index presented to the key memory
//   round_key  key memory response for round, same cycle
//   new_block  plaintext result
//   ready      idle and new_block valid
interface aes_decipher_block_if;
  logic         next;
  logic         keylen;
  logic [127:0] block;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [127:0] new_block;
  logic         ready;

  modport master (
    output next, keylen, block, round_key,
    input  round, new_block, ready
  );

  modport slave (
    input  next, keylen, block, round_key,
    output round, new_block, ready
  );
endinterface

// File: rtl/aes_decipher_block.sv
// Iterative AES-128/256 block decipher. One inverse round takes five cycles:
// four SBOX cycles (one column word through four inverse S-boxes each) and one
// ROUND cycle (AddRoundKey + InvMixColumns + InvShiftRows). An INIT cycle adds
// the last round key first; total latency is 1 + 5*Nr cycles.
// Ports: clk, reset (async, active-high), bus (slave side of the
// aes_decipher_block_if; round indexes the external key memory).
module aes_decipher_block (
  input logic                 clk,
  input logic                 reset,
  aes_decipher_block_if.slave bus
);

  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned ROUND_W = 4;
  localparam int unsigned WORD_W  = 2;
  localparam logic [ROUND_W-1:0] NR_128 = ROUND_W'(10);
  localparam logic [ROUND_W-1:0] NR_256 = ROUND_W'(14);

  // FIPS-197 inverse S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {IDLE, INIT, SBOX, ROUND} fsm_t;

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX_TBL[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiplies by 09/0b/0d/0e built from x, 2x, 4x, 8x.
  function automatic logic [31:0] gf_mults(input logic [7:0] b);
    logic [7:0] b2, b4, b8;
    b2 = xtime(b);
    b4 = xtime(b2);
    b8 = xtime(b4);
    return {b8 ^ b, b8 ^ b2 ^ b, b8 ^ b4 ^ b, b8 ^ b4 ^ b2};  // {09,0b,0d,0e}
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [31:0] m0, m1, m2, m3;
    m0 = gf_mults(w[31:24]);
    m1 = gf_mults(w[23:16]);
    m2 = gf_mults(w[15:8]);
    m3 = gf_mults(w[7:0]);
    // m*[7:0]=0e, [15:8]=0d, [23:16]=0b, [31:24]=09
    return {m0[7:0]   ^ m1[23:16] ^ m2[15:8]  ^ m3[31:24],
            m0[31:24] ^ m1[7:0]   ^ m2[23:16] ^ m3[15:8],
            m0[15:8]  ^ m1[31:24] ^ m2[7:0]   ^ m3[23:16],
            m0[23:16] ^ m1[15:8]  ^ m2[31:24] ^ m3[7:0]};
  endfunction

  function automatic logic [BLOCK_W-1:0] inv_mix_columns(input logic [BLOCK_W-1:0] s);
    return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
            inv_mix_col(s[63:32]),  inv_mix_col(s[31:0])};
  endfunction

  // Row r rotates right by r: out(r,c) = in(r, c-r mod 4).
  function automatic logic [BLOCK_W-1:0] inv_shift_rows(input logic [BLOCK_W-1:0] s);
    return {s[127:120], s[23:16],   s[47:40],   s[71:64],
            s[95:88],   s[119:112], s[15:8],    s[39:32],
            s[63:56],   s[87:80],   s[111:104], s[7:0],
            s[31:24],   s[55:48],   s[79:72],   s[103:96]};
  endfunction

  fsm_t                 fsm_q, fsm_d;
  logic [BLOCK_W-1:0]   st_q, st_d;
  logic [BLOCK_W-1:0]   new_block_q, new_block_d;
  logic [ROUND_W-1:0]   round_q, round_d;
  logic [WORD_W-1:0]    word_q, word_d;
  logic                 ready_q, ready_d;
  logic [31:0]          sel_word, sub_word;
  logic [BLOCK_W-1:0]   keyed;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fsm_q <= IDLE;
    else       fsm_q <= fsm_d;
  end

  // Next-state logic
  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      IDLE:  if (bus.next) fsm_d = INIT;
      INIT:  fsm_d = SBOX;
      SBOX:  if (word_q == WORD_W'(3)) fsm_d = ROUND;
      ROUND: fsm_d = (round_q == '0) ? IDLE : SBOX;
    endcase
  end

  // Column word feeding the four inverse S-boxes
  always_comb begin
    sel_word = st_q[127:96];
    unique case (word_q)
      2'd0: sel_word = st_q[127:96];
      2'd1: sel_word = st_q[95:64];
      2'd2: sel_word = st_q[63:32];
      2'd3: sel_word = st_q[31:0];
    endcase
  end

  assign sub_word = {inv_sbox(sel_word[31:24]), inv_sbox(sel_word[23:16]),
                     inv_sbox(sel_word[15:8]),  inv_sbox(sel_word[7:0])};
  assign keyed    = st_q ^ bus.round_key;

  // Datapath and output next values per FSM state
  always_comb begin
    st_d        = st_q;
    new_block_d = new_block_q;
    round_d     = round_q;
    word_d      = word_q;
    ready_d     = ready_q;
    unique case (fsm_q)
      IDLE: begin
        if (bus.next) begin
          st_d    = bus.block;
          round_d = bus.keylen ? NR_256 : NR_128;
          ready_d = 1'b0;
        end
      end
      INIT: begin
        st_d    = inv_shift_rows(keyed);
        round_d = round_q - ROUND_W'(1);
        word_d  = '0;
      end
      SBOX: begin
        unique case (word_q)
          2'd0: st_d[127:96] = sub_word;
          2'd1: st_d[95:64]  = sub_word;
          2'd2: st_d[63:32]  = sub_word;
          2'd3: st_d[31:0]   = sub_word;
        endcase
        word_d = word_q + WORD_W'(1);
      end
      ROUND: begin
        if (round_q != '0) begin
          st_d    = inv_shift_rows(inv_mix_columns(keyed));
          round_d = round_q - ROUND_W'(1);
        end else begin
          new_block_d = keyed;
          ready_d     = 1'b1;
        end
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q        <= '0;
      new_block_q <= '0;
      round_q     <= '0;
      word_q      <= '0;
      ready_q     <= 1'b1;
    end else begin
      st_q        <= st_d;
      new_block_q <= new_block_d;
      round_q     <= round_d;
      word_q      <= word_d;
      ready_q     <= ready_d;
    end
  end

  assign bus.round     = round_q;
  assign bus.new_block = new_block_q;
  assign bus.ready     = ready_q;

endmodule
